combiner_n: RTL
===============

Name: combiner_n

Overview:
- N-to-1 join stage that sits directly downstream of the SIZE-lane broadcaster or any set of SIZE independent lane pipelines.
- Accepts SIZE independent valid/ready lanes, each WIDTH bits wide. Buffers each lane separately so that lane skew is absorbed.
- Emits one registered valid/ready beat carrying all SIZE lanes concatenated, only when every lane holds data.
- Sustains one beat per cycle in burst mode.

Parameters:
- SIZE, 8, number of input lanes (≥1).
- WIDTH, 32, bits per lane.
- BURST, "yes", "yes" gives 2-entry lane buffers and full throughput; "no" gives 1-entry lane buffers, and a lane accepts again only after its entry is popped.

Ports:
- iCLK  input  1  clock, rising edge.
- iRST  input  1  asynchronous, active-low reset.
- iValid_AM  input  SIZE  per-lane valid.
- oReady_AM  output  SIZE  per-lane ready.
- iData_AM  input  SIZE*WIDTH  lane i at [i*WIDTH+:WIDTH].
- oValid_BM  output  1  joined beat valid.
- iReady_BM  input  1  downstream ready.
- oData_BM  output  SIZE*WIDTH  joined beat; lane i at [i*WIDTH+:WIDTH].

Behaviour:
- Reset (iRST low, asynchronous):
  - All lane buffers empty; lane counts = 0.
  - oValid_BM = 0, oData_BM = 0, oReady_AM = all 0 while iRST is low.
  - First ready is asserted at the first edge after release.
- Lane buffer i is a FIFO of depth D = 2 ("yes") or D = 1 ("no"). Count is cnt_i in 0..D.
  - oReady_AM[i] = (cnt_i < D), decoded from registered state only. It has no combinational path from iReady_BM.
  - Push: iValid_AM[i] && oReady_AM[i].
- Join condition: J = every lane cnt_i > 0 AND (output register empty OR iReady_BM).
- Pop when J is true: head of every lane is popped on the same edge and loaded into the output register. oValid_BM = 1 on the next cycle.
- Output register: holds oData_BM stable and oValid_BM high until iReady_BM is sampled high. If J is false and iReady_BM is high, oValid_BM clears.
- Simultaneous push and pop on one lane: count unchanged. Data ordering is preserved: pushed data goes behind the head.
  - When D = 1, cnt_i = 1 means ready is low, so simultaneous push and pop cannot occur on that lane.
- Latency: last-arriving lane handshake at edge t gives oValid_BM high in the cycle after edge t+1, i.e. 2 edges.
- Throughput:
  - "yes": 1 beat/cycle when all lanes stream and iReady_BM = 1.
  - "no": 1 beat per 2 cycles.
- Skew:
  - An early lane may run up to D beats ahead. Beyond that its ready drops until the slowest lane catches up.
  - Beats are never reordered or mixed across join boundaries. Output beat k contains the k-th accepted word of every lane.
- Backpressure: with iReady_BM = 0 and oValid_BM = 1, each lane fills to D and then deasserts ready. No data is lost or duplicated.
- Reset mid-operation: buffered and output data are discarded immediately; oValid_BM drops asynchronously.
- SIZE = 1: degenerates to a (D+1)-deep pipeline buffer.

Decomposition:
- Shared package/include: BURST string constants and depth derivation (D = 2 or 1).
- Counter width is 2 bits fixed. No typedefs are needed beyond that.
- Natural sub-module: lane_buffer (WIDTH, DEPTH).
  - Ports: push valid/ready/data, pop strobe, non-empty flag, head data, iCLK, iRST.
  - combiner_n instantiates SIZE of these plus the output register and join logic.

Test Plan (SIZE=4, WIDTH=8 unless noted):
1. Reset then aligned stream: lanes driven with {0x03,0x02,0x01,0x00} every cycle and iReady_BM=1 → first oValid_BM 2 edges after the first handshake, oData_BM=0x03020100, then 1 beat/cycle with no bubbles.
2. Skew: lane 0 sends 0xA0, 0xA1 at cycles 0-1; lanes 1-3 send 0xB0/0xC0/0xD0 at cycle 5 and then 0xB1/0xC1/0xD1 → oReady_AM[0]=0 from cycle 2 until the first pop; outputs are 0xD0C0B0A0 then 0xD1C1B1A1, in order.
3. Backpressure: iReady_BM=0 for 6 cycles with all lanes valid → oValid_BM=1 with oData_BM constant, every oReady_AM low after the buffers fill (D=2); on release, the 1 output-register beat plus 2 buffered beats drain in consecutive cycles with no loss.
4. BURST="no": continuous valid on all lanes, iReady_BM=1 → oReady_AM alternates 1/0 and output throughput is 1 beat per 2 cycles.
5. Async reset mid-stream: assert iRST low between clock edges while 2 beats are buffered → oValid_BM and oReady_AM go 0 immediately; after release, the first beat out is newly pushed data and no stale values appear.
6. SIZE=1, WIDTH=32: push 0xDEADBEEF, 0x12345678 with a random iReady_BM pattern → both words emitted in order exactly once.

Source files
------------

// File: rtl/combiner_n_pkg.sv
// rtl/combiner_n_pkg.sv - shared constants for the combiner_n join stage
// BURST selector strings, per-lane buffer depths and count width.
package combiner_n_pkg;

  localparam string BURST_NO     = "no";
  localparam int    DEPTH_BURST  = 2;
  localparam int    DEPTH_SINGLE = 1;
  localparam int    CNT_W        = 2;

endpackage

// File: rtl/combiner_n_lane_buffer.sv
// rtl/combiner_n_lane_buffer.sv - per-lane FIFO of depth 1 or 2
// Ready is a registered decode of the next count, so it stays low through reset.
module combiner_n_lane_buffer
  import combiner_n_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             push_valid,
  output logic             push_ready,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             not_empty,
  output logic [WIDTH-1:0] head_data
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ready_q, ready_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  logic             push;

  assign push       = push_valid && ready_q;
  assign push_ready = ready_q;
  assign not_empty  = (cnt_q != '0);
  assign head_data  = head_q;

  always_comb begin
    cnt_d  = cnt_q;
    head_d = head_q;
    tail_d = tail_q;
    case ({push, pop})
      2'b10: begin
        cnt_d = cnt_q + ONE_C;
        if (cnt_q == '0) head_d = push_data;
        else             tail_d = push_data;
      end
      2'b01: begin
        cnt_d  = cnt_q - ONE_C;
        head_d = tail_q;
      end
      2'b11: begin
        // new word always lands behind whatever remains after the pop
        if (cnt_q == ONE_C) begin
          head_d = push_data;
        end else begin
          head_d = tail_q;
          tail_d = push_data;
        end
      end
      default: ;
    endcase
    ready_d = (cnt_d < DEPTH_C);
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      cnt_q   <= '0;
      ready_q <= 1'b0;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

endmodule

// File: rtl/combiner_n.sv
// rtl/combiner_n.sv - SIZE-lane join into one registered concatenated beat
// Each lane is buffered independently; all heads pop together into the output register.
module combiner_n
  import combiner_n_pkg::*;
#(
  parameter int    SIZE  = 8,
  parameter int    WIDTH = 32,
  parameter string BURST = "yes"
) (
  input  logic                  iCLK,
  input  logic                  iRST,
  input  logic [SIZE-1:0]       iValid_AM,
  output logic [SIZE-1:0]       oReady_AM,
  input  logic [SIZE*WIDTH-1:0] iData_AM,
  output logic                  oValid_BM,
  input  logic                  iReady_BM,
  output logic [SIZE*WIDTH-1:0] oData_BM
);

  localparam int D = (BURST == BURST_NO) ? DEPTH_SINGLE : DEPTH_BURST;

  logic [SIZE-1:0]       lane_ne;
  logic [SIZE*WIDTH-1:0] heads;
  logic                  join_en;
  logic                  valid_q, valid_d;
  logic [SIZE*WIDTH-1:0] data_q, data_d;

  for (genvar i = 0; i < SIZE; i++) begin : g_lane
    combiner_n_lane_buffer #(
      .WIDTH (WIDTH),
      .DEPTH (D)
    ) u_buf (
      .iCLK       (iCLK),
      .iRST       (iRST),
      .push_valid (iValid_AM[i]),
      .push_ready (oReady_AM[i]),
      .push_data  (iData_AM[i*WIDTH +: WIDTH]),
      .pop        (join_en),
      .not_empty  (lane_ne[i]),
      .head_data  (heads[i*WIDTH +: WIDTH])
    );
  end

  assign join_en = (&lane_ne) && (!valid_q || iReady_BM);

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (join_en) begin
      valid_d = 1'b1;
      data_d  = heads;
    end else if (iReady_BM) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign oValid_BM = valid_q;
  assign oData_BM  = data_q;

endmodule
